biquad8_pole_coeff_loader: RTL and testbench

Sequencer that programs the 4-DSP coefficient cascade of the biquad8 pole IIR stage. The host writes four 18-bit pole coefficients into shadow registers. A commit shifts them serially down the B-cascade (B1 registers) and then issues a single update strobe. That strobe transfers all four coefficients into the active B2 registers on the same clock edge, so the filter never runs with a mixed coefficient set. The block sits between the register/control interface and the pole IIR instance.

---
 rtl/biquad8_pole_coeff_loader.sv | 136 +++++++++++++
 tb/tb_biquad8_pole_coeff_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad8_pole_coeff_loader.sv
// +--------------------------------------------------------------------------+
// | biquad8_pole_coeff_loader                                                |
// | Shadow coefficient set, serial B1 cascade load, single B2 update strobe. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module biquad8_pole_coeff_loader #(
  parameter logic [17:0] INIT_C0       = 18'h0,
  parameter logic [17:0] INIT_C1       = 18'h0,
  parameter logic [17:0] INIT_C2       = 18'h0,
  parameter logic [17:0] INIT_C3       = 18'h0,
  parameter bit          LOAD_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_i,
  input  logic [1:0]  addr_i,
  input  logic [17:0] dat_i,
  input  logic        commit_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [17:0] coeff_dat_o,
  output logic        coeff_wr_o,
  output logic        coeff_update_o
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_shift  = 2'd1;
  localparam logic [1:0] c_st_update = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_cnt;
  logic        r_pending;
  logic [17:0] r_shadow [0:3];
  logic [17:0] r_snap   [0:3];
  logic        r_busy;
  logic        r_done;
  logic        r_wr;
  logic        r_update;
  logic [17:0] r_dat;

  logic        w_go;
  logic [1:0]  w_cnt_nxt;
  logic [1:0]  w_idx_nxt;

  assign w_go      = commit_i | r_pending;
  assign w_cnt_nxt = r_cnt + 2'd1;
  // Next word to present is snapshot[3 - (cnt + 1)].
  assign w_idx_nxt = 2'd2 - r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow[0] <= INIT_C0;
      r_shadow[1] <= INIT_C1;
      r_shadow[2] <= INIT_C2;
      r_shadow[3] <= INIT_C3;
    end else if (wr_i) begin
      r_shadow[addr_i] <= dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_cnt     <= 2'd0;
      r_pending <= LOAD_ON_RESET;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr      <= 1'b0;
      r_update  <= 1'b0;
      r_dat     <= 18'h0;
      for (int i = 0; i < 4; i++) begin
        r_snap[i] <= 18'h0;
      end
    end else begin
      r_done   <= 1'b0;
      r_update <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_go) begin
            // Shadow reads here are pre-write, so a same-cycle write misses this load.
            for (int i = 0; i < 4; i++) begin
              r_snap[i] <= r_shadow[i];
            end
            r_state   <= c_st_shift;
            r_pending <= 1'b0;
            r_cnt     <= 2'd0;
            r_busy    <= 1'b1;
            r_wr      <= 1'b1;
            r_dat     <= r_shadow[3];
          end
        end
        c_st_shift: begin
          if (commit_i) begin
            r_pending <= 1'b1;
          end
          if (r_cnt == 2'd3) begin
            r_state  <= c_st_update;
            r_wr     <= 1'b0;
            r_dat    <= 18'h0;
            r_update <= 1'b1;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_nxt;
            r_dat <= r_snap[w_idx_nxt];
          end
        end
        c_st_update: begin
          if (commit_i) begin
            r_pending <= 1'b1;
          end
          r_state <= c_st_idle;
          r_cnt   <= 2'd0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= c_st_idle;
          r_cnt   <= 2'd0;
          r_busy  <= 1'b0;
          r_wr    <= 1'b0;
          r_dat   <= 18'h0;
        end
      endcase
    end
  end

  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign coeff_wr_o     = r_wr;
  assign coeff_update_o = r_update;
  assign coeff_dat_o    = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_biquad8_pole_coeff_loader.sv
// +--------------------------------------------------------------------------+
// | tb_biquad8_pole_coeff_loader                                             |
// | Scoreboard bench with a B1/B2 cascade model of the pole filter.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_biquad8_pole_coeff_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [17:0] dat_i = 18'h0;
  logic        commit_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [17:0] coeff_dat_o;
  logic        coeff_wr_o;
  logic        coeff_update_o;

  always #5 clk = ~clk;

  biquad8_pole_coeff_loader #(
    .INIT_C0(18'd1),
    .INIT_C1(18'd2),
    .INIT_C2(18'd3),
    .INIT_C3(18'd4),
    .LOAD_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_i(wr_i),
    .addr_i(addr_i),
    .dat_i(dat_i),
    .commit_i(commit_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .coeff_dat_o(coeff_dat_o),
    .coeff_wr_o(coeff_wr_o),
    .coeff_update_o(coeff_update_o)
  );

  typedef struct {
    int          cyc;
    bit          upd;
    logic [17:0] dat;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          sb_on = 1'b1;
  int          run_len = 0;
  logic [17:0] sh [4];
  logic [17:0] b1 [4] = '{default: 18'h0};
  logic [17:0] b2 [4] = '{default: 18'h0};

  always @(posedge clk) cyc <= cyc + 1;

  // Filter-side cascade: data enters DSP0 and shifts toward DSP3.
  always @(posedge clk) begin
    if (coeff_wr_o) begin
      b1[0] <= coeff_dat_o;
      b1[1] <= b1[0];
      b1[2] <= b1[1];
      b1[3] <= b1[2];
    end
    if (coeff_update_o) begin
      for (int i = 0; i < 4; i++) b2[i] <= b1[i];
    end
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each active edge.
  always begin
    logic [21:0] act;
    logic [21:0] req;
    exp_t        e;
    @(posedge clk);
    #1;
    act = {busy_o, done_o, coeff_wr_o, coeff_update_o, coeff_dat_o};
    chk("wr_update_exclusive", {71'h0, coeff_wr_o & coeff_update_o}, 72'h0);
    if (rst) begin
      run_len = 0;
      chk("reset_outputs", {50'h0, act}, 72'h0);
    end else begin
      if (coeff_update_o) begin
        chk("writes_before_update", 72'(run_len), 72'd4);
        run_len = 0;
      end else if (coeff_wr_o) begin
        run_len++;
      end
      if (sb_on) begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk("event_cycle", 72'(e.cyc), 72'(cyc));
          req = e.upd ? {4'b1101, 18'h0} : {4'b1010, e.dat};
          chk(e.upd ? "update_pulse" : "shift_word", {50'h0, act}, {50'h0, req});
        end else begin
          chk("idle_outputs", {50'h0, act}, 72'h0);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_load(input int e);
    for (int i = 0; i < 4; i++) q.push_back('{e + i, 1'b0, sh[3 - i]});
    q.push_back('{e + 4, 1'b1, 18'h0});
  endtask

  task automatic write(input logic [1:0] a, input logic [17:0] d);
    wr_i   = 1'b1;
    addr_i = a;
    dat_i  = d;
    sh[a]  = d;
    step();
    wr_i = 1'b0;
  endtask

  task automatic commit_now(output int e);
    commit_i = 1'b1;
    e = cyc + 1;
    push_load(e);
    step();
    commit_i = 1'b0;
  endtask

  task automatic check_b2(input string nm, input logic [17:0] c0, input logic [17:0] c1,
                          input logic [17:0] c2, input logic [17:0] c3);
    chk(nm, {b2[3], b2[2], b2[1], b2[0]}, {c3, c2, c1, c0});
  endtask

  initial begin
    int e;
    int e2;
    sh[0] = 18'd1; sh[1] = 18'd2; sh[2] = 18'd3; sh[3] = 18'd4;

    // Automatic load of the INIT set after reset release.
    repeat (3) step();
    rst = 1'b0;
    e = cyc + 1;
    push_load(e);
    wait_cyc(e + 6);
    check_b2("b2_after_reset_load", 18'd1, 18'd2, 18'd3, 18'd4);

    // Basic commit.
    write(2'd0, 18'h00011);
    write(2'd1, 18'h00022);
    write(2'd2, 18'h00033);
    write(2'd3, 18'h00044);
    step();
    commit_now(e);
    wait_cyc(e + 6);
    check_b2("b2_basic_commit", 18'h11, 18'h22, 18'h33, 18'h44);

    // Two commits during the shift collapse into one back-to-back reload.
    commit_now(e);
    wait_cyc(e + 1);
    commit_i = 1'b1;
    step();
    step();
    commit_i = 1'b0;
    push_load(e + 6);
    wait_cyc(e + 14);
    check_b2("b2_collapsed_reload", 18'h11, 18'h22, 18'h33, 18'h44);

    // Write during a load affects only the following load.
    commit_now(e);
    wait_cyc(e + 1);
    write(2'd0, 18'h3FFFF);
    wait_cyc(e + 6);
    check_b2("b2_old_c0_kept", 18'h11, 18'h22, 18'h33, 18'h44);
    commit_now(e2);
    wait_cyc(e2 + 6);
    check_b2("b2_new_c0", 18'h3FFFF, 18'h22, 18'h33, 18'h44);

    // Write in the same cycle as the snapshot is excluded from that load.
    commit_i = 1'b1;
    wr_i     = 1'b1;
    addr_i   = 2'd3;
    dat_i    = 18'h12345;
    e = cyc + 1;
    push_load(e);
    sh[3] = 18'h12345;
    step();
    commit_i = 1'b0;
    wr_i     = 1'b0;
    wait_cyc(e + 6);
    check_b2("b2_snapshot_prewrite", 18'h3FFFF, 18'h22, 18'h33, 18'h44);
    commit_now(e);
    wait_cyc(e + 6);
    check_b2("b2_after_simul_write", 18'h3FFFF, 18'h22, 18'h33, 18'h12345);

    // Reset mid-shift: no update, B2 keeps the old set, then INIT reload.
    write(2'd1, 18'h2ABCD);
    step();
    commit_i = 1'b1;
    e = cyc + 1;
    q.push_back('{e, 1'b0, sh[3]});
    q.push_back('{e + 1, 1'b0, sh[2]});
    step();
    commit_i = 1'b0;
    wait_cyc(e + 1);
    rst = 1'b1;
    repeat (3) step();
    check_b2("b2_kept_after_abort", 18'h3FFFF, 18'h22, 18'h33, 18'h12345);
    sh[0] = 18'd1; sh[1] = 18'd2; sh[2] = 18'd3; sh[3] = 18'd4;
    rst = 1'b0;
    e = cyc + 1;
    push_load(e);
    wait_cyc(e + 6);
    check_b2("b2_reload_after_abort", 18'd1, 18'd2, 18'd3, 18'd4);

    // Random writes and commits; protocol checks stay active.
    sb_on = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      wr_i     = ($urandom_range(0, 3) == 0);
      addr_i   = 2'($urandom_range(0, 3));
      dat_i    = 18'($urandom);
      commit_i = ($urandom_range(0, 15) == 0);
      if (wr_i) sh[addr_i] = dat_i;
      step();
    end
    wr_i     = 1'b0;
    commit_i = 1'b0;
    repeat (20) step();
    sb_on = 1'b1;
    commit_now(e);
    wait_cyc(e + 6);
    check_b2("b2_after_random", sh[0], sh[1], sh[2], sh[3]);

    for (int i = 0; i < 50 && q.size() > 0; i++) step();
    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL unseen_event expected_cyc=%0d actual=none required=seen", q[0].cyc);
      void'(q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
